// File: rtl/cpu_sequencer_if.sv
// Memory bus between the RV32I control sequencer and the shared instruction/data memory.
// The sequencer drives the master side; memory or a testbench drives the slave side.
interface cpu_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch over the shared bus into the
// instruction register, decode, optional data access, writeback and PC update.
// Optional feature macro: CPU_SEQ_TIMEOUT_EN adds an 8-bit bus wait counter that
// drops the request and parks the FSM in FAULT (sticky fault_o) when no ack arrives.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   halt_i,
  cpu_sequencer_if.master        bus,
  output logic [31:0]            instr_o,
  output logic                   dec_en_o,
  input  logic [1:0]             dec_next_pc_sel_i,
  input  logic [31:0]            dec_addr_i,
  input  logic                   dec_addr_valid_i,
  input  logic                   dec_we_i,
  input  logic                   dec_reg_in_en_i,
  output logic                   rf_we_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            load_data_o,
  output logic [2:0]             state_o,
  output logic                   fault_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] next_pc;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q;
  logic       fault_q;
  assign fault_o = fault_q;
`else
  // Without the timeout feature the limit has no effect; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign fault_o = 1'b0;
`endif

  assign bus.bus_req  = bus_req_q;
  assign bus.bus_we   = bus_we_q;
  assign bus.bus_addr = bus_addr_q;
  assign state_o      = state_q;

  // Next PC from the decoder's selection; 32-bit wrap-around is intended.
  always_comb begin
    next_pc = pc_o + 32'd4;
    case (dec_next_pc_sel_i)
      2'b01:   next_pc = pc_o + dec_addr_i;
      2'b11:   next_pc = dec_addr_i;
      default: next_pc = pc_o + 32'd4;
    endcase
  end

  // Sequencer FSM; every output is registered and set up on the transition into its state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_o        <= RESET_PC;
      instr_o     <= 32'd0;
      load_data_o <= 32'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= RESET_PC;
      dec_en_o    <= 1'b0;
      rf_we_o     <= 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
      wait_cnt_q  <= 8'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      rf_we_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!halt_i) begin
            state_q    <= FETCH;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= pc_o;
`ifdef CPU_SEQ_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
`endif
          end
        end

        FETCH: begin
          if (bus.bus_ack) begin
            instr_o   <= bus.bus_rdata;
            bus_req_q <= 1'b0;
            dec_en_o  <= 1'b1;
            state_q   <= DECODE;
          end
`ifdef CPU_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= FAULT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end

        DECODE: begin
          if (dec_addr_valid_i) begin
            state_q    <= MEM;
            bus_req_q  <= 1'b1;
            bus_we_q   <= dec_we_i;
            bus_addr_q <= dec_addr_i;
`ifdef CPU_SEQ_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
`endif
          end else begin
            state_q <= WB;
            rf_we_o <= dec_reg_in_en_i;
          end
        end

        MEM: begin
          if (bus.bus_ack) begin
            if (!bus_we_q) begin
              load_data_o <= bus.bus_rdata;
            end
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            rf_we_o   <= dec_reg_in_en_i;
            state_q   <= WB;
          end
`ifdef CPU_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            dec_en_o  <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= FAULT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end

        WB: begin
          pc_o     <= next_pc;
          dec_en_o <= 1'b0;
          if (halt_i) begin
            state_q <= IDLE;
          end else begin
            state_q    <= FETCH;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= next_pc;
`ifdef CPU_SEQ_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
`endif
          end
        end

        FAULT: begin
          state_q   <= FAULT;
          bus_req_q <= 1'b0;
          bus_we_q  <= 1'b0;
          dec_en_o  <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
          bus_we_q  <= 1'b0;
          dec_en_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: the bench plays memory and decoder, and tracks the
// expected PC, instruction register and load data at instruction level.
module tb_cpu_sequencer;

  localparam logic [31:0] RESET_PC       = 32'h0000_0000;
  localparam int          TIMEOUT_CYCLES = 255;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [31:0] instr;
  logic        dec_en;
  logic [1:0]  dec_next_pc_sel;
  logic [31:0] dec_addr;
  logic        dec_addr_valid;
  logic        dec_we;
  logic        dec_reg_in_en;
  logic        rf_we;
  logic [31:0] pc;
  logic [31:0] load_data;
  logic [2:0]  state;
  logic        fault;

  int compare_count  = 0;
  int mismatch_count = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_load;

  cpu_sequencer_if bus_if ();

  cpu_sequencer #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .halt_i            (halt),
    .bus               (bus_if),
    .instr_o           (instr),
    .dec_en_o          (dec_en),
    .dec_next_pc_sel_i (dec_next_pc_sel),
    .dec_addr_i        (dec_addr),
    .dec_addr_valid_i  (dec_addr_valid),
    .dec_we_i          (dec_we),
    .dec_reg_in_en_i   (dec_reg_in_en),
    .rf_we_o           (rf_we),
    .pc_o              (pc),
    .load_data_o       (load_data),
    .state_o           (state),
    .fault_o           (fault)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Architectural PC rule: relative jump, absolute jump, or sequential.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [1:0] sel,
                                                input logic [31:0] a);
    if (sel == 2'b01) return cur + a;
    if (sel == 2'b11) return a;
    return cur + 32'd4;
  endfunction

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.bus_req !== 1'b1) check_output(tag, 32'(bus_if.bus_req), 32'd1);
  endtask

  // Runs one instruction end to end while acting as memory and decoder.
  task automatic apply_stimulus(input logic [1:0] sel, input logic [31:0] daddr, input logic av,
                                input logic st, input logic rie, input int fwait, input int mwait,
                                input logic halt_here, input logic [31:0] fetch_word,
                                input logic [31:0] mem_word);
    wait_req("fetch_req");
    check_output("fetch_addr", bus_if.bus_addr, exp_pc);
    check_output("fetch_we", 32'(bus_if.bus_we), 32'd0);
    for (int i = 0; i < fwait; i++) begin
      @(negedge clk);
      check_output("fetch_hold_req", 32'(bus_if.bus_req), 32'd1);
      check_output("fetch_hold_addr", bus_if.bus_addr, exp_pc);
      check_output("instr_stable", instr, exp_instr);
    end
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = fetch_word;
    dec_next_pc_sel  = sel;
    dec_addr         = daddr;
    dec_addr_valid   = av;
    dec_we           = st;
    dec_reg_in_en    = rie;
    @(negedge clk);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = $urandom();
    exp_instr        = fetch_word;
    check_output("instr_load", instr, exp_instr);
    check_output("decode_state", 32'(state), 32'(ST_DECODE));
    check_output("decode_req", 32'(bus_if.bus_req), 32'd0);
    check_output("decode_en", 32'(dec_en), 32'd1);
    if (halt_here) halt = 1'b1;
    @(negedge clk);
    if (av) begin
      check_output("mem_state", 32'(state), 32'(ST_MEM));
      check_output("mem_req", 32'(bus_if.bus_req), 32'd1);
      check_output("mem_we", 32'(bus_if.bus_we), 32'(st));
      check_output("mem_addr", bus_if.bus_addr, daddr);
      for (int i = 0; i < mwait; i++) begin
        @(negedge clk);
        check_output("mem_hold_req", 32'(bus_if.bus_req), 32'd1);
        check_output("mem_hold_we", 32'(bus_if.bus_we), 32'(st));
        check_output("mem_hold_addr", bus_if.bus_addr, daddr);
      end
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = mem_word;
      @(negedge clk);
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = $urandom();
      if (!st) exp_load = mem_word;
    end
    check_output("wb_state", 32'(state), 32'(ST_WB));
    check_output("wb_rf_we", 32'(rf_we), 32'(rie));
    check_output("wb_dec_en", 32'(dec_en), 32'd1);
    check_output("wb_pc_stable", pc, exp_pc);
    check_output("wb_load_data", load_data, exp_load);
    check_output("wb_req", 32'(bus_if.bus_req), 32'd0);
    exp_pc = model_next_pc(exp_pc, sel, daddr);
    @(negedge clk);
    check_output("pc_update", pc, exp_pc);
    check_output("rf_we_pulse", 32'(rf_we), 32'd0);
    if (halt_here) begin
      check_output("halt_idle", 32'(state), 32'(ST_IDLE));
      for (int i = 0; i < 3; i++) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = $urandom();
        @(negedge clk);
        check_output("halt_req", 32'(bus_if.bus_req), 32'd0);
        check_output("halt_state", 32'(state), 32'(ST_IDLE));
        check_output("halt_instr", instr, exp_instr);
      end
      bus_if.bus_ack = 1'b0;
      halt = 1'b0;
      @(negedge clk);
      check_output("resume_req", 32'(bus_if.bus_req), 32'd1);
      check_output("resume_addr", bus_if.bus_addr, exp_pc);
    end else begin
      check_output("next_fetch_req", 32'(bus_if.bus_req), 32'd1);
      check_output("next_fetch_addr", bus_if.bus_addr, exp_pc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    check_output({tag, "_pc"}, pc, RESET_PC);
    check_output({tag, "_instr"}, instr, 32'd0);
    check_output({tag, "_load"}, load_data, 32'd0);
    check_output({tag, "_fault"}, 32'(fault), 32'd0);
    check_output({tag, "_req"}, 32'(bus_if.bus_req), 32'd0);
    check_output({tag, "_we"}, 32'(bus_if.bus_we), 32'd0);
    check_output({tag, "_dec_en"}, 32'(dec_en), 32'd0);
    check_output({tag, "_rf_we"}, 32'(rf_we), 32'd0);
  endtask

  // Main sequence: reset, directed instructions, random instructions, reset and bus-stall cases.
  initial begin
    rst_n            = 1'b0;
    halt             = 1'b0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;
    dec_next_pc_sel  = 2'b00;
    dec_addr         = 32'd0;
    dec_addr_valid   = 1'b0;
    dec_we           = 1'b0;
    dec_reg_in_en    = 1'b0;
    exp_pc           = RESET_PC;
    exp_instr        = 32'd0;
    exp_load         = 32'd0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // ADDI x1,x0,5 then a slow fetch, SW, LW, jumps, halt and PC wrap.
    apply_stimulus(2'b00, 32'd0,         1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0050_0093, 32'd0);
    apply_stimulus(2'b10, 32'h1234,      1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 32'h0000_0013, 32'd0);
    apply_stimulus(2'b00, 32'h100,       1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 32'h1020_2023, 32'h5555_AAAA);
    apply_stimulus(2'b00, 32'h200,       1'b1, 1'b0, 1'b1, 1, 2, 1'b0, 32'h2000_2083, 32'hDEAD_BEEF);
    apply_stimulus(2'b11, 32'h20,        1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0000_0013, 32'd0);
    apply_stimulus(2'b01, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'hFF9F_F0EF, 32'd0);
    apply_stimulus(2'b11, 32'h40,        1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0400_00E7, 32'd0);
    apply_stimulus(2'b00, 32'h300,       1'b1, 1'b0, 1'b1, 0, 1, 1'b1, 32'h3000_2103, 32'h0BAD_F00D);
    apply_stimulus(2'b11, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0000_0067, 32'd0);
    apply_stimulus(2'b00, 32'd0,         1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0000_0013, 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  r_sel;
      logic [31:0] r_addr;
      logic        r_av;
      logic        r_st;
      r_sel  = 2'($urandom_range(0, 3));
      r_addr = (r_sel == 2'b01) ? 32'($signed(12'($urandom()))) : $urandom();
      r_av   = 1'($urandom_range(0, 1));
      r_st   = 1'($urandom_range(0, 1));
      apply_stimulus(r_sel, r_addr, r_av, r_st, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), $urandom(), $urandom());
    end

    // Reset in the middle of a stalled fetch.
    wait_req("midfetch_req");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midfetch_reset");
    @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = RESET_PC;
    exp_instr = 32'd0;
    exp_load  = 32'd0;
    wait_req("stall_req");
    check_output("stall_addr", bus_if.bus_addr, RESET_PC);

`ifdef CPU_SEQ_TIMEOUT_EN
    begin
      int held;
      held = 0;
      while (bus_if.bus_req === 1'b1 && held < 400) begin
        @(negedge clk);
        held++;
      end
      check_output("timeout_cycles", 32'(held), 32'(TIMEOUT_CYCLES));
      check_output("timeout_fault", 32'(fault), 32'd1);
      check_output("timeout_state", 32'(state), 32'(ST_FAULT));
      for (int i = 0; i < 4; i++) begin
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        check_output("fault_req", 32'(bus_if.bus_req), 32'd0);
        check_output("fault_sticky", 32'(fault), 32'd1);
        check_output("fault_state", 32'(state), 32'(ST_FAULT));
      end
      bus_if.bus_ack = 1'b0;
    end
`else
    repeat (300) @(negedge clk);
    check_output("nowait_req", 32'(bus_if.bus_req), 32'd1);
    check_output("nowait_state", 32'(state), 32'(ST_FETCH));
    check_output("nowait_fault", 32'(fault), 32'd0);
    check_output("nowait_addr", bus_if.bus_addr, RESET_PC);
`endif

    rst_n = 1'b0;
    #1;
    check_reset_state("final_reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
